// File: rtl/data_mem_responder.sv
// 512-byte big-endian wait-state data memory answering the MEM-stage controls.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses instead of force-aligning them.
module data_mem_responder #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable,
  input  logic        mem_rw,
  input  logic [1:0]  mem_size,
  input  logic        mem_se,
  input  logic [8:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_error
);

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              se_q, se_d;
  logic              rw_q, rw_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     data_out_q, data_out_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;

  logic [7:0]        mem_q [DEPTH];

  logic [AW-1:0]     eff_addr;
  logic              misaligned;
  logic [AW-1:0]     lane_addr [LANES];
  logic [7:0]        rd_byte   [LANES];
  logic [7:0]        wr_data   [LANES];
  logic [LANES-1:0]  lane_mask;
  logic [LANES-1:0]  wr_en;
  logic [DW-1:0]     load_val;

  // Effective address and misalignment decode from the latched request
  always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
    eff_addr   = addr_q;
    misaligned = size_q[1] ? (addr_q[1:0] != 2'b00) : (size_q[0] & addr_q[0]);
`else
    misaligned = 1'b0;
    if (size_q[1])      eff_addr = {addr_q[8:2], 2'b00};
    else if (size_q[0]) eff_addr = {addr_q[8:1], 1'b0};
    else                eff_addr = addr_q;
`endif
  end

  // Byte lanes: lane i addresses eff_addr+i, lane 0 carries the most significant byte
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      lane_addr[i] = eff_addr + AW'(i);
      rd_byte[i]   = mem_q[lane_addr[i]];
      wr_data[i]   = 8'h00;
    end
    lane_mask = 4'b0000;
    load_val  = '0;
    case (size_q)
      2'b00: begin
        lane_mask  = 4'b0001;
        wr_data[0] = wdata_q[7:0];
        load_val   = {{24{se_q & rd_byte[0][7]}}, rd_byte[0]};
      end
      2'b01: begin
        lane_mask  = 4'b0011;
        wr_data[0] = wdata_q[15:8];
        wr_data[1] = wdata_q[7:0];
        load_val   = {{16{se_q & rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
      end
      default: begin
        lane_mask  = 4'b1111;
        wr_data[0] = wdata_q[31:24];
        wr_data[1] = wdata_q[23:16];
        wr_data[2] = wdata_q[15:8];
        wr_data[3] = wdata_q[7:0];
        load_val   = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
      end
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    se_d       = se_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    busy_d     = 1'b0;
    error_d    = 1'b0;
    wr_en      = '0;
    case (state_q)
      ST_IDLE: begin
        if (mem_enable) begin
          addr_d  = address;
          size_d  = mem_size;
          se_d    = mem_se;
          rw_d    = mem_rw;
          wdata_d = data_in;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - CNT_W'(1);
          busy_d = 1'b1;
        end else begin
          state_d = ST_DONE;
          ready_d = 1'b1;
          error_d = misaligned;
          if (!misaligned) begin
            if (rw_q) wr_en      = lane_mask;
            else      data_out_d = load_val;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      se_q       <= 1'b0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      se_q       <= se_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  // Storage array keeps its contents across reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (wr_en[i]) mem_q[lane_addr[i]] <= wr_data[i];
    end
  end

  assign data_out  = data_out_q;
  assign mem_ready = ready_q;
  assign mem_busy  = busy_q;
  assign mem_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;

  localparam int unsigned W = 3;

  logic        clk;
  logic        reset;
  logic        mem_enable;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic        mem_se;
  logic [8:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_error;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mm [512];
  logic [31:0] m_dout;
  logic        m_err;

  data_mem_responder #(.WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_enable (mem_enable),
    .mem_rw     (mem_rw),
    .mem_size   (mem_size),
    .mem_se     (mem_se),
    .address    (address),
    .data_in    (data_in),
    .data_out   (data_out),
    .mem_ready  (mem_ready),
    .mem_busy   (mem_busy),
    .mem_error  (mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte array, big-endian, access size in bytes
  task automatic model_access(input logic rw, input logic [1:0] sz, input logic se,
                              input logic [8:0] a, input logic [31:0] d);
    int n;
    int ai;
    int ea;
    logic [31:0] v;
    n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    ai = int'(a);
`ifdef DMEM_ALIGN_CHECK_EN
    m_err = (ai % n) != 0;
    ea    = ai;
`else
    m_err = 1'b0;
    ea    = ai - (ai % n);
`endif
    if (!m_err) begin
      if (rw) begin
        for (int i = 0; i < n; i++) mm[ea + i] = 8'(d >> (8 * (n - 1 - i)));
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | {24'd0, mm[ea + i]};
        if (se && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        m_dout = v;
      end
    end
  endtask

  task automatic drive(input logic rw, input logic [1:0] sz, input logic se,
                       input logic [8:0] a, input logic [31:0] d);
    mem_enable = 1'b1;
    mem_rw     = rw;
    mem_size   = sz;
    mem_se     = se;
    address    = a;
    data_in    = d;
  endtask

  // Called #1 after the accept edge; follows the access to its ready pulse
  task automatic finish_access(input string tag);
    int lat;
    lat        = 0;
    mem_enable = 1'b0;
    mem_rw     = 1'($urandom);
    mem_size   = 2'($urandom);
    mem_se     = 1'($urandom);
    address    = 9'($urandom);
    data_in    = $urandom;
    chk({tag, "/busy_accept"}, {31'd0, mem_busy}, 32'd1);
    chk({tag, "/ready_accept"}, {31'd0, mem_ready}, 32'd0);
    for (int k = 1; k <= int'(W) + 4; k++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        lat = k;
        break;
      end
      chk({tag, "/busy_wait"}, {31'd0, mem_busy}, 32'd1);
    end
    chk({tag, "/latency"}, 32'(lat), 32'(W + 1));
    chk({tag, "/busy_done"}, {31'd0, mem_busy}, 32'd0);
    chk({tag, "/data_out"}, data_out, m_dout);
    chk({tag, "/error"}, {31'd0, mem_error}, {31'd0, m_err});
    @(posedge clk); #1;
    chk({tag, "/ready_drop"}, {31'd0, mem_ready}, 32'd0);
    chk({tag, "/error_drop"}, {31'd0, mem_error}, 32'd0);
  endtask

  task automatic run_access(input string tag, input logic rw, input logic [1:0] sz,
                            input logic se, input logic [8:0] a, input logic [31:0] d);
    model_access(rw, sz, se, a, d);
    @(negedge clk);
    drive(rw, sz, se, a, d);
    @(posedge clk); #1;
    finish_access(tag);
  endtask

  initial begin
    logic [31:0] prev;
    int per;
    reset      = 1'b1;
    mem_enable = 1'b0;
    mem_rw     = 1'b0;
    mem_size   = 2'b00;
    mem_se     = 1'b0;
    address    = '0;
    data_in    = '0;
    m_dout     = 32'd0;
    m_err      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset/data_out", data_out, 32'd0);
    chk("reset/ready", {31'd0, mem_ready}, 32'd0);
    chk("reset/busy", {31'd0, mem_busy}, 32'd0);
    chk("reset/error", {31'd0, mem_error}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 128; i++) run_access("init", 1'b1, 2'b10, 1'b0, 9'(4 * i), $urandom);

    run_access("st_word", 1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF);
    run_access("ld_word", 1'b0, 2'b10, 1'b0, 9'h010, 32'd0);
    chk("plan/word", data_out, 32'hDEADBEEF);
    run_access("ld_b10", 1'b0, 2'b00, 1'b0, 9'h010, 32'd0);
    chk("plan/b10", data_out, 32'h000000DE);
    run_access("ld_b13", 1'b0, 2'b00, 1'b0, 9'h013, 32'd0);
    chk("plan/b13", data_out, 32'h000000EF);
    run_access("ld_b11_se", 1'b0, 2'b00, 1'b1, 9'h011, 32'd0);
    chk("plan/b11_se", data_out, 32'hFFFFFFAD);
    run_access("ld_b11_ze", 1'b0, 2'b00, 1'b0, 9'h011, 32'd0);
    chk("plan/b11_ze", data_out, 32'h000000AD);
    run_access("st_half", 1'b1, 2'b01, 1'b0, 9'h012, 32'hFFFF1234);
    chk("plan/st_hold", data_out, 32'h000000AD);
    run_access("ld_word2", 1'b0, 2'b10, 1'b0, 9'h010, 32'd0);
    chk("plan/word2", data_out, 32'hDEAD1234);
    run_access("ld_half_se", 1'b0, 2'b01, 1'b1, 9'h012, 32'd0);
    chk("plan/half_se", data_out, 32'h00001234);
    run_access("ld_half_neg", 1'b0, 2'b01, 1'b1, 9'h010, 32'd0);
    chk("plan/half_neg", data_out, 32'hFFFFDEAD);

    prev = data_out;
    run_access("ld_misal", 1'b0, 2'b11, 1'b0, 9'h013, 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("plan/misal_hold", data_out, prev);
`else
    chk("plan/misal_word", data_out, 32'hDEAD1234);
`endif

    // Requester holding enable high: accesses repeat every W+3 cycles
    model_access(1'b0, 2'b10, 1'b0, 9'h010, 32'd0);
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 9'h010, 32'd0);
    for (int c = 0; c < 3 * (int'(W) + 3); c++) begin
      @(posedge clk); #1;
      per = c % (int'(W) + 3);
      chk("hold/busy", {31'd0, mem_busy}, {31'd0, per <= int'(W)});
      chk("hold/ready", {31'd0, mem_ready}, {31'd0, per == int'(W) + 1});
      if (per == int'(W) + 1) chk("hold/data", data_out, m_dout);
    end
    mem_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold/idle_busy", {31'd0, mem_busy}, 32'd0);

    // Store aborted by reset while waiting
    run_access("st_b20", 1'b1, 2'b00, 1'b0, 9'h020, 32'h000000A7);
    run_access("ld_b20", 1'b0, 2'b00, 1'b1, 9'h020, 32'd0);
    chk("plan/b20_before", data_out, 32'hFFFFFFA7);
    @(negedge clk);
    drive(1'b1, 2'b00, 1'b0, 9'h020, 32'h00000055);
    @(posedge clk); #1;
    mem_enable = 1'b0;
    @(posedge clk); #1;
    chk("abort/busy_before", {31'd0, mem_busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    m_dout = 32'd0;
    chk("abort/data_out", data_out, 32'd0);
    chk("abort/ready", {31'd0, mem_ready}, 32'd0);
    chk("abort/busy", {31'd0, mem_busy}, 32'd0);
    chk("abort/error", {31'd0, mem_error}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < int'(W) + 5; k++) begin
      @(posedge clk); #1;
      chk("abort/no_ready", {31'd0, mem_ready}, 32'd0);
    end
    run_access("ld_b20_after", 1'b0, 2'b00, 1'b0, 9'h020, 32'd0);
    chk("plan/b20_after", data_out, 32'h000000A7);

    // Reset released with a request already pending
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 2'b10, 1'b0, 9'h010, 32'd0);
    m_dout = 32'd0;
    model_access(1'b0, 2'b10, 1'b0, 9'h010, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    finish_access("rel_en");

    for (int i = 0; i < 300; i++) begin
      run_access("rand", 1'($urandom), 2'($urandom), 1'($urandom), 9'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Wait-state data memory that answers the memory-stage control signals (`mem_enable`, `mem_rw`, `mem_size`, `mem_se`) produced by the EX/MEM pipeline register.

- It holds 512 bytes, stored big-endian and byte-addressed, matching the instruction memory layout.
- Each request runs through a small FSM with a programmable wait-state counter.
- It returns a one-cycle `mem_ready` pulse, plus formatted load data.
- It drives `mem_busy` so the hazard logic can hold PC/nPC and the pipeline registers.

## Interface

- `WAIT_CYCLES`, default 1: extra wait states per access, legal range 0–15.
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high. Clears the FSM and all outputs. The memory array is not cleared.
- `mem_enable`: input, 1 bit. Access request, sampled in IDLE.
- `mem_rw`: input, 1 bit. 0 = load, 1 = store.
- `mem_size`: input, 2 bits. 00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
- `mem_se`: input, 1 bit. On loads, 1 = sign-extend and 0 = zero-extend; ignored for word accesses.
- `address`: input, 9 bits. Byte address.
- `data_in`: input, 32 bits. Store data, right-justified.
- `data_out`: output, 32 bits. Registered load result.
- `mem_ready`: output, 1 bit. One-cycle completion pulse.
- `mem_busy`: output, 1 bit. High while a request is in flight (WAIT state).
- `mem_error`: output, 1 bit. Misalignment flag, qualified by `mem_ready`. Exists only with `DMEM_ALIGN_CHECK_EN`; otherwise tied to 0.

## Operation

**FSM states:** IDLE, WAIT, DONE.

- **IDLE**
  - When `mem_enable` is 1 at a rising edge, latch `address`, `mem_size`, `mem_se`, `mem_rw` and `data_in`.
  - Load the counter with `WAIT_CYCLES` and go to WAIT.
- **WAIT**
  - If the counter is nonzero, decrement it.
  - If the counter is 0, perform the access using the latched fields and go to DONE.
- **DONE**
  - `mem_ready` is 1; go to IDLE on the next edge unconditionally.
  - `mem_enable` is ignored in DONE. A requester that keeps it high is re-accepted in IDLE as a new access.
- Input changes after the accept edge have no effect on the access in flight.

**Load formatting:**
- Byte: `data_out = ext(Mem[a])`.
- Halfword: `data_out = ext({Mem[a], Mem[a+1]})`.
- Word: `data_out = {Mem[a], Mem[a+1], Mem[a+2], Mem[a+3]}`.
- `ext` sign-extends from the top bit when `mem_se` = 1, and zero-fills otherwise.

**Store formatting:**
- Byte: writes `data_in[7:0]` to `Mem[a]`.
- Halfword: writes `data_in[15:8]` to `a` and `data_in[7:0]` to `a+1`.
- Word: writes all four bytes, MSB at `a`.
- Bytes outside the access size are untouched.
- `data_out` holds its previous value on stores.

**Addressing:** with alignment enforced, aligned accesses never cross address 511, so no wrap logic exists.

## Timing

- **Reset values:** state IDLE, `data_out` = 0, `mem_ready` = 0, `mem_busy` = 0, `mem_error` = 0, counter = 0.
- **Latency:**
  - Accept edge E0.
  - The access is performed at edge E(WAIT_CYCLES+1), after which `mem_ready` is high for exactly one cycle.
  - `data_out` is valid in that same cycle and holds until the next load completes.
- **`mem_busy`:** high in every cycle the FSM is in WAIT; low in IDLE and DONE.
- **Throughput:** one access per `WAIT_CYCLES` + 3 cycles.
- **Reset mid-operation:** an in-flight store is dropped and memory is unchanged. `mem_ready` never pulses for the aborted request.
- **Reset released with `mem_enable` = 1:** the request is accepted at the first rising edge after release.

## Configuration

`DMEM_ALIGN_CHECK_EN`

- **Defined:**
  - An access is misaligned when it is a halfword with `address[0]` = 1, or a word/size-11 access with `address[1:0]` ≠ 00.
  - A misaligned access still walks the full FSM.
  - At completion it performs no write, leaves `data_out` unchanged, and asserts `mem_error` together with `mem_ready` for one cycle.
- **Undefined:**
  - `address[0]` is forced to 0 for halfwords, and `address[1:0]` to 00 for words.
  - The access proceeds normally and `mem_error` is constant 0.

## Test plan

- **Word round trip.** With `WAIT_CYCLES` = 1: store word 0xDEADBEEF at 0x010, then load word at 0x010.
  - `mem_ready` pulses 2 edges after each accept.
  - `data_out` = 0xDEADBEEF.
  - Bytes 0x010–0x013 read DE, AD, BE, EF.
- **Byte loads and sign extension.** Load byte 0x011 with `mem_se` = 1 → 0xFFFFFFAD; with `mem_se` = 0 → 0x000000AD.
- **Halfword store.** Store halfword 0x1234 at 0x012, then load word 0x010 → 0xDEAD1234. Then load halfword 0x012 with `mem_se` = 1 → 0x00001234.
- **Busy window.** With `WAIT_CYCLES` = 3, hold `mem_enable` high continuously.
  - `mem_busy` is high for 4 cycles per access.
  - `mem_ready` pulses every 6 cycles.
  - No back-to-back ready pulses.
- **Reset mid-operation.** Assert `reset` during WAIT of a store of 0x55 to byte 0x020.
  - All outputs go to 0 immediately.
  - `Mem[0x020]` keeps its old value.
  - No `mem_ready` pulse follows.
- **Misaligned word load at 0x013.**
  - With `DMEM_ALIGN_CHECK_EN`: `mem_error` = 1 with `mem_ready`, and `data_out` is unchanged.
  - Without it: the word at 0x010 is returned.
